fetch_ctrl: RTL and testbench

//  Sequences the IF stage and the IF_ID pipeline register. Owns the PC, turns
//  i-cache hit/miss into IF_ID write/bubble control, and runs the refill

---
 rtl/fetch_ctrl_pkg.sv | 12 +
 rtl/fetch_ctrl_if.sv | 32 +++
 rtl/fetch_ctrl_sat_counter.sv | 19 +
 rtl/fetch_ctrl.sv | 94 +++++++++
 tb/tb_fetch_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM states and
// fetch granularity.
package fetch_ctrl_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        MISS  = 1'b1
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Signal bundle between the fetch controller and its neighbours: the i-cache,
// the IF_ID register, and the hazard/branch logic.
interface fetch_ctrl_if #(
    parameter int ADDR_W     = 32,
    parameter int MISS_CNT_W = 16
);
    logic                  icache_hit;
    logic                  icache_req;
    logic [ADDR_W-1:0]     icache_addr;
    logic                  icache_ready;
    logic                  id_stall;
    logic                  br_taken;
    logic [ADDR_W-1:0]     br_target;
    logic [ADDR_W-1:0]     pc;
    logic [ADDR_W-1:0]     next_pc;
    logic                  ifid_we;
    logic                  ifid_flush;
    logic                  ifid_hit;
    logic [MISS_CNT_W-1:0] miss_count;

    modport master (
        input  icache_hit, icache_ready, id_stall, br_taken, br_target,
        output icache_req, icache_addr, pc, next_pc, ifid_we, ifid_flush,
               ifid_hit, miss_count
    );

    modport slave (
        output icache_hit, icache_ready, id_stall, br_taken, br_target,
        input  icache_req, icache_addr, pc, next_pc, ifid_we, ifid_flush,
               ifid_hit, miss_count
    );
endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the PC, turns i-cache hit/miss into IF_ID load or
// bubble control, runs the refill handshake and applies redirects and stalls.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                MISS_CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc_r, pc_nxt;
    logic [ADDR_W-1:0] miss_addr, miss_addr_nxt;
    logic              req_r, req_nxt;
    logic              miss_inc;
    logic              we, flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc_r      <= RESET_PC;
            req_r     <= 1'b0;
            miss_addr <= '0;
        end else begin
            state     <= state_nxt;
            pc_r      <= pc_nxt;
            req_r     <= req_nxt;
            miss_addr <= miss_addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc_r;
        miss_addr_nxt = miss_addr;
        req_nxt       = req_r;
        we            = 1'b0;
        flush         = 1'b0;
        miss_inc      = 1'b0;
        case (state)
            FETCH: begin
                if (bus.br_taken) begin
                    pc_nxt = bus.br_target;
                    flush  = 1'b1;
                end else if (bus.id_stall) begin
                    // IF_ID holds; nothing advances
                end else if (bus.icache_hit) begin
                    pc_nxt = pc_r + ADDR_W'(INSTR_BYTES);
                    we     = 1'b1;
                end else begin
                    flush         = 1'b1;
                    miss_addr_nxt = pc_r;
                    req_nxt       = 1'b1;
                    miss_inc      = 1'b1;
                    state_nxt     = MISS;
                end
            end
            MISS: begin
                // A redirect lands in pc but the refill of miss_addr still completes.
                flush = bus.br_taken | ~bus.id_stall;
                if (bus.br_taken) begin
                    pc_nxt = bus.br_target;
                end
                if (bus.icache_ready) begin
                    req_nxt   = 1'b0;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    sat_counter #(
        .W(MISS_CNT_W)
    ) u_miss_cnt (
        .clk(clk),
        .clr(rst),
        .inc(miss_inc),
        .q  (bus.miss_count)
    );

    assign bus.pc          = pc_r;
    assign bus.next_pc     = pc_r + ADDR_W'(INSTR_BYTES);
    assign bus.icache_req  = req_r;
    assign bus.icache_addr = miss_addr;
    assign bus.ifid_we     = we;
    assign bus.ifid_flush  = flush;
    assign bus.ifid_hit    = bus.icache_hit & we;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a driver pushes expected per-cycle outputs
// from a behavioural model, and a negedge monitor pops and compares them.
module tb_fetch_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [31:0] addr;
        logic        req;
        logic        we;
        logic        flush;
        logic        hit;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference state: where fetch is, whether a refill is outstanding.
    logic [31:0] m_pc;
    logic [31:0] m_maddr;
    logic [15:0] m_cnt;
    bit          m_missing;

    fetch_ctrl_if #(.ADDR_W(32), .MISS_CNT_W(16)) bus ();

    fetch_ctrl #(
        .ADDR_W    (32),
        .RESET_PC  (32'h0),
        .MISS_CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc",         bus.pc,                  e.pc);
            chk("next_pc",    bus.next_pc,             e.next_pc);
            chk("icache_req", {31'd0, bus.icache_req}, {31'd0, e.req});
            if (e.req) chk("icache_addr", bus.icache_addr, e.addr);
            chk("ifid_we",    {31'd0, bus.ifid_we},    {31'd0, e.we});
            chk("ifid_flush", {31'd0, bus.ifid_flush}, {31'd0, e.flush});
            chk("ifid_hit",   {31'd0, bus.ifid_hit},   {31'd0, e.hit});
            chk("miss_count", {16'd0, bus.miss_count}, {16'd0, e.cnt});
        end
    end

    // One clock of stimulus; expected outputs for this cycle come from the model.
    task automatic step(input bit r, input bit h, input bit rdy, input bit st,
                        input bit br, input logic [31:0] tgt, input bit push = 1'b1);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        bus.icache_hit   = h;
        bus.icache_ready = rdy;
        bus.id_stall     = st;
        bus.br_taken     = br;
        bus.br_target    = tgt;

        e.pc      = m_pc;
        e.next_pc = m_pc + 32'd4;
        e.req     = m_missing;
        e.addr    = m_maddr;
        e.cnt     = m_cnt;
        e.we      = 1'b0;
        e.flush   = 1'b0;
        if (m_missing)   e.flush = br || !st;
        else if (br)     e.flush = 1'b1;
        else if (!st) begin
            if (h) e.we = 1'b1;
            else   e.flush = 1'b1;
        end
        e.hit = h && e.we;
        if (push) exp_q.push_back(e);

        if (r) begin
            m_pc = 32'h0; m_maddr = 32'h0; m_cnt = 16'h0; m_missing = 1'b0;
        end else if (m_missing) begin
            if (br)  m_pc = tgt;
            if (rdy) m_missing = 1'b0;
        end else if (br) begin
            m_pc = tgt;
        end else if (!st) begin
            if (h) m_pc = m_pc + 32'd4;
            else begin
                m_maddr   = m_pc;
                m_missing = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 1ms", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.icache_hit = 0; bus.icache_ready = 0; bus.id_stall = 0;
        bus.br_taken = 0; bus.br_target = '0;

        step(1, 0, 0, 0, 0, 0, 1'b0);
        step(1, 0, 0, 0, 0, 0);
        // 1: streaming hits 0,4,8,C
        repeat (4) step(0, 1, 0, 0, 0, 0);
        // 2: miss at 0x10, refill after 5 cycles, then hit
        step(0, 0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // 3: redirect during refill of 0x10
        step(0, 0, 0, 0, 1, 32'h10);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h80);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // 4: stall holds, branch beats stall
        step(0, 1, 0, 0, 1, 32'h20);
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 1, 1, 32'h40);
        step(0, 1, 0, 0, 0, 0);
        // 5: branch and refill completion together
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 32'h200);
        step(0, 1, 0, 0, 0, 0);
        // pc wraps past all-ones
        step(0, 1, 0, 0, 1, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // 6: reset in the middle of a refill
        step(0, 0, 0, 0, 1, 32'h300);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // miss counter saturation from a preloaded near-full value
        step(0, 1, 0, 1, 0, 0);
        @(negedge clk);
        #1;
        force dut.u_miss_cnt.q = 16'hFFFE;
        #1;
        release dut.u_miss_cnt.q;
        m_cnt = 16'hFFFE;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit r, h, rdy, st, br;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 199) == 0);
            h   = ($urandom_range(0, 9) < 7);
            rdy = m_missing && ($urandom_range(0, 3) == 0);
            st  = ($urandom_range(0, 99) < 15);
            br  = ($urandom_range(0, 9) == 0);
            tgt = $urandom();
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            step(r, h, rdy, st, br, tgt);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
